uart_rx_sampler: RTL and testbench
==================================

// Module: uart_rx_sampler
// PURPOSE
//  Upstream of the RX deserializer: synchronises RX line, runs oversampling edge/bit counters, majority-votes
//  3 mid-bit samples into sampled_bit. Feeds deserializer (sampled_bit, edge_count) and RX FSM (bit_count,
//  bit_done, start_glitch). edge_count==PRESCALE-1 is the deserializer's shift slot; sampled_bit stable by then.
// PARAMETERS
//  PRESCALE  8  clk cycles per UART bit; power of two, >=8 (8 drives the 3-bit deserializer edge_count)
//  BIT_W     4  bit_count width; covers start+8 data+parity+stop = 11 bits
//  EDGE_W    $clog2(PRESCALE)  localparam, not overridable
// PORTS
//  clk           in   1       system clock, all flops on rising edge
//  rst           in   1       asynchronous, active-high reset
//  rx_in         in   1       raw serial line, asynchronous, idle high
//  en            in   1       count/sample enable from RX FSM (high from start-bit detect to frame end)
//  rx_sync       out  1       rx_in after 2-flop synchroniser (FSM start-bit detect)
//  edge_count    out  EDGE_W  oversample phase within current bit, 0..PRESCALE-1
//  bit_count     out  BIT_W   bit index in frame, 0 = start bit
//  sampled_bit   out  1       majority value of current bit
//  bit_done      out  1       1-cycle pulse on last edge of each bit
//  start_glitch  out  1       1-cycle pulse: start bit voted 1 (false start)
// BEHAVIOUR
//  Reset (async, rst=1): sync flops=1, rx_sync=1, edge_count=0, bit_count=0, sampled_bit=1, vote regs=3'b111,
//   bit_done=0, start_glitch=0. Release takes effect on next clk edge; no output glitches mid-reset.
//  Synchroniser: rx_sync = rx_in delayed 2 clk; free-running, independent of en.
//  Counters (en=1): edge_count +1 per clk, wraps PRESCALE-1 -> 0; on that wrap bit_count +1.
//   bit_count wraps 2^BIT_W-1 -> 0 (FSM drops en long before; no saturation logic).
//  en=0: edge_count and bit_count cleared to 0 on next clk; sampled_bit holds last value.
//  en rising: first enabled cycle shows edge_count=0, bit_count=0 (count starts the cycle after en seen).
//  Sampling (en=1, all on rx_sync): capture s0 at edge M-1, s1 at edge M, s2 at edge M+1, M=PRESCALE/2.
//   At edge M+2: sampled_bit <= (s0&s1)|(s0&s2)|(s1&s2); visible from edge M+3 through next bit's M+2.
//   For PRESCALE=8: samples at 3,4,5; update at 6; valid at 7 (deserializer shift slot).
//  bit_done: registered, =1 for exactly the cycle where edge_count==PRESCALE-1 and en=1.
//  start_glitch: asserted the cycle after the vote at bit_count==0 if vote result==1; FSM must drop en.
//  en falling mid-bit: counters clear, partial vote discarded (vote regs reset to 3'b111 on next en=0 clk),
//   no bit_done, no start_glitch generated.
//  Simultaneous en=0 and edge_count==PRESCALE-1: en wins; no bit_done, no bit_count increment.
//  rst mid-frame: all state to reset values immediately; counting resumes only on fresh en.
//  Single-cycle line glitch in any sample window is filtered by the 2-of-3 vote.
// STRUCTURE
//  Shared package uart_rx_pkg: PRESCALE default, BIT_W, frame length constants (START_IDX=0, STOP_IDX by
//   parity config), majority-vote function maj3().
//  One sub-module natural: uart_rx_sync2 (2-flop synchroniser, reset value 1). Counters and vote inline.
// TESTING
//  1 rst=1 with rx_in=0 -> rx_sync=1, sampled_bit=1, edge_count=0, bit_count=0, pulses 0; release, en=0 -> unchanged.
//  2 en=1, rx_in=0 for 8 clk then 0x55 LSB-first, 8 clk/bit -> sampled_bit at each edge_count==7 = 0,1,0,1,0,1,0,1,0;
//    bit_done 9 pulses spaced 8 clk; bit_count reaches 9.
//  3 Start bit with rx_sync=1 at edges 3 and 5, 0 at 4 -> vote 1, start_glitch pulses once at edge 7, bit_count 0.
//  4 Data bit 1 with single-clk 0 at edge 4 -> sampled_bit=1; same glitch at edges 3 and 4 -> sampled_bit=0.
//  5 en dropped at edge_count=5 of bit 3 -> next clk edge_count=0, bit_count=0, no bit_done; en high with
//    edge_count==7 dropping same cycle -> no bit_done, bit_count unchanged then 0.
//  6 rst pulse (1 clk, async, between edges) at bit 4 edge 2 -> all outputs at reset values within same cycle;
//    new frame after release decodes 0xA3 correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_pkg
//  Purpose  : Shared constants and helpers for the UART receive path:
//             default oversampling ratio, bit counter width, frame index
//             constants and the 2-of-3 majority vote used on mid-bit samples.
//  Revision : 1.0  initial release
// ============================================================================
package uart_rx_pkg;

    // Oversampling ratio (clk cycles per UART bit) and bit counter width
    localparam int PRESCALE_DEF = 8;
    localparam int BIT_W_DEF    = 4;

    // Frame layout: start bit, 8 data bits, optional parity bit, stop bit
    localparam int START_IDX      = 0;
    localparam int DATA_BITS      = 8;
    localparam int STOP_IDX_NOPAR = START_IDX + DATA_BITS + 1;
    localparam int STOP_IDX_PAR   = STOP_IDX_NOPAR + 1;

    typedef enum logic {
        PAR_NONE = 1'b0,
        PAR_ON   = 1'b1
    } parity_cfg_e;

    // Three mid-bit samples of one UART bit
    typedef logic [2:0] vote_t;

    // Index of the stop bit for a given parity configuration
    function automatic int stop_idx(input parity_cfg_e cfg);
        return (cfg == PAR_ON) ? STOP_IDX_PAR : STOP_IDX_NOPAR;
    endfunction

    // 2-of-3 majority vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync2.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_sync2
//  Purpose  : Two-flop synchroniser for the asynchronous serial line.
//             Both flops reset to 1 so the line reads idle out of reset.
//  Ports    : clk  in  system clock
//             rst  in  asynchronous active-high reset
//             d_i  in  asynchronous input
//             q_o  out synchronised output (d_i delayed by 2 clk)
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_sampler
//  Purpose  : Front end of the UART receiver. Synchronises the RX line, runs
//             the oversampling edge/bit counters and majority-votes three
//             mid-bit samples into sampled_bit.
//  Ports    : clk          in   system clock
//             rst          in   asynchronous active-high reset
//             rx_in        in   raw serial line (idle high)
//             en           in   count/sample enable from RX FSM
//             rx_sync      out  synchronised line (start-bit detect)
//             edge_count   out  oversample phase within current bit
//             bit_count    out  bit index in frame, 0 = start bit
//             sampled_bit  out  majority value of current bit
//             bit_done     out  pulse on last edge of each bit
//             start_glitch out  pulse when the start bit votes 1
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter  int PRESCALE = PRESCALE_DEF,
    parameter  int BIT_W    = BIT_W_DEF,
    localparam int EDGE_W   = $clog2(PRESCALE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic              en,
    output logic              rx_sync,
    output logic [EDGE_W-1:0] edge_count,
    output logic [BIT_W-1:0]  bit_count,
    output logic              sampled_bit,
    output logic              bit_done,
    output logic              start_glitch
);

    localparam int MID = PRESCALE / 2;

    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(PRESCALE - 1);
    localparam logic [EDGE_W-1:0] EDGE_PRE  = EDGE_W'(PRESCALE - 2);
    localparam logic [EDGE_W-1:0] EDGE_S0   = EDGE_W'(MID - 1);
    localparam logic [EDGE_W-1:0] EDGE_S1   = EDGE_W'(MID);
    localparam logic [EDGE_W-1:0] EDGE_S2   = EDGE_W'(MID + 1);
    localparam logic [EDGE_W-1:0] EDGE_VOTE = EDGE_W'(MID + 2);
    localparam logic [BIT_W-1:0]  BIT_START = BIT_W'(START_IDX);

    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [BIT_W-1:0]  bitc_q, bitc_d;
    vote_t             vote_q, vote_d;
    logic              sampled_q, sampled_d;
    logic              done_q, done_d;
    logic              glitch_q, glitch_d;
    logic              vote_maj;

    uart_rx_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_in),
        .q_o (rx_sync)
    );

    assign vote_maj = maj3(vote_q[0], vote_q[1], vote_q[2]);

    always_comb begin
        // Disabled: counters clear, partial vote discarded, sampled_bit holds
        edge_d    = '0;
        bitc_d    = '0;
        vote_d    = 3'b111;
        sampled_d = sampled_q;
        done_d    = 1'b0;
        glitch_d  = 1'b0;
        if (en) begin
            edge_d = (edge_q == EDGE_LAST) ? '0 : edge_q + EDGE_W'(1);
            bitc_d = (edge_q == EDGE_LAST) ? bitc_q + BIT_W'(1) : bitc_q;
            vote_d = vote_q;
            if (edge_q == EDGE_S0) vote_d[0] = rx_sync;
            if (edge_q == EDGE_S1) vote_d[1] = rx_sync;
            if (edge_q == EDGE_S2) vote_d[2] = rx_sync;
            if (edge_q == EDGE_VOTE) begin
                sampled_d = vote_maj;
                glitch_d  = (bitc_q == BIT_START) && vote_maj;
            end
            // Registered one cycle early so the pulse lines up with EDGE_LAST
            done_d = (edge_q == EDGE_PRE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_q    <= '0;
            bitc_q    <= '0;
            vote_q    <= 3'b111;
            sampled_q <= 1'b1;
            done_q    <= 1'b0;
            glitch_q  <= 1'b0;
        end else begin
            edge_q    <= edge_d;
            bitc_q    <= bitc_d;
            vote_q    <= vote_d;
            sampled_q <= sampled_d;
            done_q    <= done_d;
            glitch_q  <= glitch_d;
        end
    end

    assign edge_count   = edge_q;
    assign bit_count    = bitc_q;
    assign sampled_bit  = sampled_q;
    // en dropping in the last-edge cycle suppresses the pulse (en wins)
    assign bit_done     = done_q & en;
    assign start_glitch = glitch_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_sampler
//  Purpose  : Directed self-checking bench for uart_rx_sampler (PRESCALE=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_sampler;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic       en;
    logic       rx_sync;
    logic [2:0] edge_count;
    logic [3:0] bit_count;
    logic       sampled_bit;
    logic       bit_done;
    logic       start_glitch;

    int n_chk  = 0;
    int n_pass = 0;

    uart_rx_sampler #(.PRESCALE(8), .BIT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_in        (rx_in),
        .en           (en),
        .rx_sync      (rx_sync),
        .edge_count   (edge_count),
        .bit_count    (bit_count),
        .sampled_bit  (sampled_bit),
        .bit_done     (bit_done),
        .start_glitch (start_glitch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive inputs just after a rising edge, then settle to the falling edge
    task automatic drive_cycle(input logic rxv, input logic env);
        @(posedge clk);
        #1;
        rx_in = rxv;
        en    = env;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".rx_sync"},      32'(rx_sync),      32'd1);
        chk({tag, ".edge_count"},   32'(edge_count),   32'd0);
        chk({tag, ".bit_count"},    32'(bit_count),    32'd0);
        chk({tag, ".sampled_bit"},  32'(sampled_bit),  32'd1);
        chk({tag, ".bit_done"},     32'(bit_done),     32'd0);
        chk({tag, ".start_glitch"}, 32'(start_glitch), 32'd0);
    endtask

    // Sends nbits bits (8 clk each). en rises two cycles after the stream so
    // rx_sync of edge k lines up with stream cycle k. en drops at cycle drop_k;
    // if rst_k == drop_k an async reset pulse is applied inside that cycle.
    task automatic run(input logic [15:0] bits, input int nbits, input int gbit,
                       input logic [7:0] gmask, input logic [15:0] expv,
                       input int drop_k, input int rst_k);
        int   total;
        int   k;
        int   last;
        logic rxv;
        logic env;
        total = nbits * 8;
        for (int t = 0; t < total + 5; t++) begin
            k = t - 2;
            if (k > drop_k + 1) break;
            rxv = 1'b1;
            if (t < total) rxv = bits[t/8] ^ ((t/8 == gbit) ? gmask[t%8] : 1'b0);
            env = (k >= 0) && (k < drop_k);
            drive_cycle(rxv, env);
            if (k >= 0 && k < drop_k && k < total) begin
                chk("edge_count",   32'(edge_count),   32'(k % 8));
                chk("bit_count",    32'(bit_count),    32'((k / 8) % 16));
                chk("bit_done",     32'(bit_done),     32'(k % 8 == 7));
                chk("start_glitch", 32'(start_glitch), 32'((k == 7) && expv[0]));
                if (k % 8 == 7)
                    chk("sampled_bit", 32'(sampled_bit), 32'(expv[k/8]));
            end
            if (k == total && k < drop_k) begin
                chk("end.edge_count", 32'(edge_count), 32'd0);
                chk("end.bit_count",  32'(bit_count),  32'(nbits));
            end
            if (k == drop_k) begin
                chk("drop.edge_count", 32'(edge_count), 32'(k % 8));
                chk("drop.bit_count",  32'(bit_count),  32'((k / 8) % 16));
                chk("drop.bit_done",   32'(bit_done),   32'd0);
                if (k == rst_k) begin
                    #1 rst = 1'b1;
                    #1 chk_reset_vals("midrst");
                    #1 rst = 1'b0;
                end
            end
            if (k == drop_k + 1) begin
                chk("clr.edge_count",   32'(edge_count),   32'd0);
                chk("clr.bit_count",    32'(bit_count),    32'd0);
                chk("clr.bit_done",     32'(bit_done),     32'd0);
                chk("clr.start_glitch", 32'(start_glitch), 32'd0);
                last = (drop_k % 8 == 7) ? drop_k / 8 : drop_k / 8 - 1;
                chk("hold.sampled_bit", 32'(sampled_bit),
                    (rst_k >= 0) ? 32'd1 : 32'(expv[last]));
            end
        end
    endtask

    initial begin
        // Reset with the line held low
        rst   = 1'b1;
        rx_in = 1'b0;
        en    = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_reset_vals("reset");

        // Release between edges; synchroniser shows the 0 two edges later
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("sync.delay1", 32'(rx_sync), 32'd1);
        @(posedge clk); #1;
        chk("sync.delay2", 32'(rx_sync), 32'd0);
        rx_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle.rx_sync",     32'(rx_sync),     32'd1);
        chk("idle.edge_count",  32'(edge_count),  32'd0);
        chk("idle.bit_count",   32'(bit_count),   32'd0);
        chk("idle.sampled_bit", 32'(sampled_bit), 32'd1);

        // Start bit + 0x55 LSB-first
        run({7'd0, 8'h55, 1'b0}, 9, -1, 8'h00, {7'd0, 8'h55, 1'b0}, 73, -1);
        // en dropped at bit 3 edge 5
        run({7'd0, 8'h55, 1'b0}, 9, -1, 8'h00, {7'd0, 8'h55, 1'b0}, 29, -1);
        // en dropped in the same cycle edge_count reaches 7 (bit 1)
        run({7'd0, 8'h55, 1'b0}, 9, -1, 8'h00, {7'd0, 8'h55, 1'b0}, 15, -1);
        // False start: start bit reads 1 at edges 3 and 5
        run(16'h0000, 1, 0, 8'h28, 16'h0001, 8, -1);
        // Data bit 1 with single-cycle 0 at edge 4 -> filtered
        run(16'h0002, 2, 1, 8'h10, 16'h0002, 17, -1);
        // Data bit 1 with 0 at edges 3 and 4 -> votes 0
        run(16'h0002, 2, 1, 8'h18, 16'h0000, 17, -1);
        // Async reset pulse at bit 4 edge 2, line low at that moment
        run({7'd0, 8'h55, 1'b0}, 9, -1, 8'h00, {7'd0, 8'h55, 1'b0}, 34, 34);
        // Fresh frame after reset: 0xA3
        run({7'd0, 8'hA3, 1'b0}, 9, -1, 8'h00, {7'd0, 8'hA3, 1'b0}, 73, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
